// File: rtl/hs_pkg.sv
// Shared definitions for the valid/ready handshake subsystem.
//   - Default payload width and buffer depth.
//   - Width helpers for pointers and occupancy counters.
//   - Handshake beat type (payload plus valid), used by master and slave blocks.
package hs_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_DEPTH  = 4;

    // Pointer width for a power-of-two depth.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Counter width: one extra bit so that the value DEPTH itself fits.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] data;
        logic                      valid;
    } hs_beat_t;

endpackage

// File: rtl/hs_stream_fifo_if.sv
// Valid/ready stream bundle.
//   data  : payload, driven by the master
//   valid : payload offered this cycle, driven by the master
//   ready : beat accepted this cycle, driven by the slave
interface hs_stream_fifo_if
    import hs_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
);

    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );

endinterface

// File: rtl/hs_fifo_mem.sv
// Register-array storage for hs_stream_fifo.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : contents of entry raddr
module hs_fifo_mem
    import hs_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    localparam int unsigned ADDR_W = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    // Contents need no reset; readers only look at entries marked valid.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/hs_stream_fifo.sv
// First-word-fall-through valid/ready buffer between a handshake master and slave.
//   clk         : single clock, rising edge
//   reset       : synchronous, active-low
//   s           : upstream stream (this block is the slave)
//   m           : downstream stream (this block is the master); m.data is the head entry
//   count       : stored entries, 0..DEPTH
//   almost_full : count >= AFULL_TH
// All handshake outputs are registered from the next-state count, so neither
// ready nor valid has a combinational path from the opposite side.
module hs_stream_fifo
    import hs_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter int unsigned AFULL_TH = 3,
    localparam int unsigned CNT_W   = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    hs_stream_fifo_if.slave  s,
    hs_stream_fifo_if.master m,
    output logic [CNT_W-1:0] count,
    output logic             almost_full
);

    localparam int unsigned      PTR_W   = ptr_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_TH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              s_ready_q, s_ready_d;
    logic              m_valid_q, m_valid_d;
    logic              afull_q, afull_d;
    logic              push, pop;
    logic [DATA_W-1:0] rd_data;

    always_comb begin
        push     = s.valid && s_ready_q;
        pop      = m_valid_q && m.ready;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Pointers wrap naturally; full/empty come from count only.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        s_ready_d = (count_d < DEPTH_C);
        m_valid_d = (count_d != '0);
        afull_d   = (count_d >= AFULL_C);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            afull_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            afull_q   <= afull_d;
        end
    end

    // A push coinciding with reset is dropped, so keep it out of storage too.
    hs_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push && reset),
        .waddr (wr_ptr_q),
        .wdata (s.data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign s.ready     = s_ready_q;
    assign m.valid     = m_valid_q;
    assign m.data      = rd_data;
    assign count       = count_q;
    assign almost_full = afull_q;

endmodule

// File: doc/hs_stream_fifo.md
Name: hs_stream_fifo

Overview:
- Parametrised valid/ready buffering channel that sits between a handshake master and slave in the AXI-style handshake subsystem.
- Decouples the upstream (s_*) and downstream (m_*) handshakes with a DEPTH-entry first-word-fall-through store.
- Generalises the fixed 32-bit single-beat master/slave pair to arbitrary data width and depth.
- Adds occupancy reporting, an almost-full flag, and back-pressure without any combinational ready path.

Parameters:
- DATA_W, 32, width of the data payload in bits.
- DEPTH, 4, number of storage entries; must be a power of two, at least 2.
- AFULL_TH, 3, almost_full asserts when count >= AFULL_TH; legal range 1..DEPTH.
- CNT_W, $clog2(DEPTH)+1, width of the count output; derived, not overridden.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset (sampled on the clk rising edge; 0 = reset).
- s_data  in  DATA_W  upstream payload.
- s_valid  in  1  upstream offers s_data this cycle.
- s_ready  out  1  block can accept a beat this cycle.
- m_data  out  DATA_W  downstream payload (head entry).
- m_valid  out  1  head entry is valid.
- m_ready  in  1  downstream accepts m_data this cycle.
- count  out  CNT_W  number of stored entries, 0..DEPTH.
- almost_full  out  1  count >= AFULL_TH.

Behaviour:
- Reset (reset==0 at a rising edge):
  - wr_ptr, rd_ptr and count go to 0; m_valid=0; almost_full=0; s_ready=1.
  - Storage contents are don't-care; m_data is don't-care while m_valid=0.
  - Reset overrides any simultaneous push or pop, and any beat in flight is discarded.
- Push: push = s_valid && s_ready. On push, s_data is written at wr_ptr and wr_ptr advances, wrapping modulo DEPTH.
- Pop: pop = m_valid && m_ready. On pop, rd_ptr advances, wrapping modulo DEPTH.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop in the same cycle: count unchanged.
- s_ready: a register equal to (next_count < DEPTH). There is no combinational path from m_ready or s_valid to s_ready.
- m_valid: a register equal to (next_count != 0).
- m_data: the storage entry at rd_ptr (first-word fall-through).
- Latency: a beat pushed in cycle N is presented with m_valid=1 in cycle N+1 when the block was empty. There is no same-cycle bypass.
- Throughput: one beat per cycle sustained when s_valid=1 and m_ready=1 with 0 < count < DEPTH.
- Full (count==DEPTH): s_ready=0 and s_valid is ignored. A pop in the full state makes s_ready=1 in the next cycle, so there is a one-cycle bubble on the upstream side.
- Empty (count==0): m_valid=0 and m_ready is ignored. A push while empty takes count to 1.
- Handshake rules (protocol, checked by the bench):
  - While m_valid && !m_ready, m_data and m_valid hold stable.
  - The upstream must hold s_data and s_valid stable while s_valid && !s_ready.
  - m_valid never depends combinationally on m_ready.
  - The block never drops a beat and never duplicates one; ordering is strictly FIFO.
- Pointers are log2(DEPTH) bits wide and wrap naturally. Full and empty are resolved by count, not by pointer comparison.
- almost_full is registered from next_count and is updated in the same cycle as count.

Decomposition:
- Package hs_pkg:
  - Default DATA_W and DEPTH constants.
  - A clog2-based width helper.
  - The handshake beat typedef (data plus valid), shared with the master and slave blocks.
- One sub-module, hs_fifo_mem: a DEPTH x DATA_W register array with one synchronous write port and one asynchronous read port.
- Pointer, count and flag logic stays in hs_stream_fifo.

Test Plan:
- Reset, then idle: reset=0 for 10 cycles, then released -> m_valid=0, s_ready=1, count=0, almost_full=0.
- Single beat: push 32'h20220503 at cycle N with m_ready=1 -> m_valid=1 and m_data=32'h20220503 at N+1, popped at N+1, count back to 0 at N+2.
- Fill and back-pressure (DEPTH=4, m_ready=0): push 32'h10000001..32'h10000004 ->
  - count=4, s_ready=0, almost_full=1 from count=3.
  - A fifth beat 32'h10000005 held on s_valid is not accepted.
  - Raising m_ready for 1 cycle pops 32'h10000001; s_ready=1 next cycle; 32'h10000005 is then accepted.
- Streaming: s_valid=1 and m_ready=1 for 16 cycles with an incrementing payload from 32'h10000006 -> output order identical, with a gap-free stream after the first beat.
- Stall stability: m_ready toggling in a pseudo-random pattern -> m_data stays constant while m_valid && !m_ready, with no loss or duplication against a scoreboard.
- Reset mid-operation: with count=3, assert reset=0 for 1 cycle -> count=0 and m_valid=0 next cycle, and a push in the same cycle as reset is discarded.
